// File: rtl/axis_mm2s_frame_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_mm2s_frame_monitor_if
// Brief    : AXI4-Stream video bundle (tuser = SOF, tlast = EOL).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_mm2s_frame_monitor_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tuser,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tuser,
        input  tlast,
        input  tdata,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_mm2s_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axis_mm2s_frame_monitor
// Brief    : Stream sink that applies backpressure, checks frame geometry,
//            counts frames and sums pixel data per frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_mm2s_frame_monitor #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300
) (
    input  logic                           m_axis_mm2s_aclk,
    input  logic                           m_axis_mm2s_aresetn,
    input  logic                           enable,
    input  logic [7:0]                     bp_pattern,
    input  logic                           clear_err,
    axis_mm2s_frame_monitor_if.slave       s_axis,
    output logic                           frame_done,
    output logic [15:0]                    frame_count,
    output logic [15:0]                    line_count,
    output logic [31:0]                    checksum,
    output logic [3:0]                     err_status
);
    localparam int c_XW = $clog2(IMG_WIDTH);
    localparam int c_YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_HEIGHT - 1);

    localparam logic [0:0] c_WAIT_SOF = 1'b0;
    localparam logic [0:0] c_ACTIVE   = 1'b1;

    logic [0:0]      r_state,      w_state_nxt;
    logic [2:0]      r_bp_idx;
    logic [c_XW-1:0] r_x,          w_x_nxt;
    logic [c_YW-1:0] r_y,          w_y_nxt;
    logic [31:0]     r_acc,        w_acc_nxt;
    logic            r_frame_done, w_frame_done_nxt;
    logic [15:0]     r_frame_count, w_frame_count_nxt;
    logic [15:0]     r_line_count, w_line_count_nxt;
    logic [31:0]     r_checksum,   w_checksum_nxt;
    logic [3:0]      r_err,        w_err_nxt;
    logic [3:0]      w_err_set;
    logic            w_line_end;
    logic            w_beat;
    logic            w_tready;
    logic [31:0]     w_acc_sum;

    // Ready follows the rotating mask only; it is never a function of tvalid.
    assign w_tready      = enable & bp_pattern[r_bp_idx];
    assign s_axis.tready = w_tready;
    assign w_beat        = s_axis.tvalid & w_tready;
    assign w_acc_sum     = r_acc + 32'(s_axis.tdata);

    always_comb begin
        w_state_nxt       = r_state;
        w_x_nxt           = r_x;
        w_y_nxt           = r_y;
        w_acc_nxt         = r_acc;
        w_frame_done_nxt  = 1'b0;
        w_frame_count_nxt = r_frame_count;
        w_line_count_nxt  = r_line_count;
        w_checksum_nxt    = r_checksum;
        w_err_set         = 4'b0000;
        w_line_end        = 1'b0;

        case (r_state)
            c_WAIT_SOF: begin
                if (w_beat && s_axis.tuser) begin
                    w_x_nxt     = c_XW'(1);
                    w_y_nxt     = '0;
                    w_acc_nxt   = 32'(s_axis.tdata);
                    w_state_nxt = c_ACTIVE;
                end
            end
            default: begin
                if (!enable) begin
                    w_state_nxt      = c_WAIT_SOF;
                    w_err_set[3]     = 1'b1;
                    w_line_count_nxt = 16'(r_y);
                end else if (w_beat && s_axis.tuser) begin
                    // Restart from this beat; a coincident tlast is meaningless here.
                    w_err_set[0] = 1'b1;
                    w_x_nxt      = c_XW'(1);
                    w_y_nxt      = '0;
                    w_acc_nxt    = 32'(s_axis.tdata);
                end else if (w_beat) begin
                    w_acc_nxt = w_acc_sum;
                    if (s_axis.tlast && (r_x != c_X_LAST)) begin
                        w_err_set[1] = 1'b1;
                        w_line_end   = 1'b1;
                    end else if (!s_axis.tlast && (r_x == c_X_LAST)) begin
                        w_err_set[2] = 1'b1;
                        w_line_end   = 1'b1;
                    end else if (s_axis.tlast) begin
                        w_line_end = 1'b1;
                    end else begin
                        w_x_nxt = r_x + c_XW'(1);
                    end

                    if (w_line_end) begin
                        w_x_nxt = '0;
                        if (r_y == c_Y_LAST) begin
                            w_frame_done_nxt  = 1'b1;
                            w_frame_count_nxt = r_frame_count + 16'd1;
                            w_line_count_nxt  = 16'(IMG_HEIGHT);
                            w_checksum_nxt    = w_acc_sum;
                            w_state_nxt       = c_WAIT_SOF;
                        end else begin
                            w_y_nxt = r_y + c_YW'(1);
                        end
                    end
                end
            end
        endcase

        // A fresh error raised in the clearing cycle survives the clear.
        w_err_nxt = (clear_err ? 4'b0000 : r_err) | w_err_set;
    end

    always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
        if (!m_axis_mm2s_aresetn) begin
            r_state       <= c_WAIT_SOF;
            r_bp_idx      <= 3'd0;
            r_x           <= '0;
            r_y           <= '0;
            r_acc         <= 32'd0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
            r_line_count  <= 16'd0;
            r_checksum    <= 32'd0;
            r_err         <= 4'b0000;
        end else begin
            r_state       <= w_state_nxt;
            r_bp_idx      <= r_bp_idx + 3'd1;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_acc         <= w_acc_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_line_count  <= w_line_count_nxt;
            r_checksum    <= w_checksum_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign line_count  = r_line_count;
    assign checksum    = r_checksum;
    assign err_status  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_axis_mm2s_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_mm2s_frame_monitor
// Brief    : Directed self-checking bench for axis_mm2s_frame_monitor (8x4 frames).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_mm2s_frame_monitor;
    localparam int DATA_WIDTH = 16;
    localparam int IMG_WIDTH  = 8;
    localparam int IMG_HEIGHT = 4;

    logic        clk;
    logic        rst_n;
    logic        r_enable;
    logic [7:0]  r_bp;
    logic        r_clear_err;
    logic        w_frame_done;
    logic [15:0] w_frame_count;
    logic [15:0] w_line_count;
    logic [31:0] w_checksum;
    logic [3:0]  w_err;

    int n_compared;
    int n_mismatched;
    int n_done_pulses;

    axis_mm2s_frame_monitor_if #(.DATA_WIDTH(DATA_WIDTH)) axis_if ();

    axis_mm2s_frame_monitor #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_dut (
        .m_axis_mm2s_aclk    (clk),
        .m_axis_mm2s_aresetn (rst_n),
        .enable              (r_enable),
        .bp_pattern          (r_bp),
        .clear_err           (r_clear_err),
        .s_axis              (axis_if.slave),
        .frame_done          (w_frame_done),
        .frame_count         (w_frame_count),
        .line_count          (w_line_count),
        .checksum            (w_checksum),
        .err_status          (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (w_frame_done === 1'b1) n_done_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [15:0] data, input logic user, input logic last);
        bit accepted;
        accepted = 1'b0;
        for (int i = 0; i < 32 && !accepted; i++) begin
            axis_if.tvalid = 1'b1;
            axis_if.tdata  = data;
            axis_if.tuser  = user;
            axis_if.tlast  = last;
            #1;
            accepted = axis_if.tready;
            @(posedge clk);
            @(negedge clk);
        end
        axis_if.tvalid = 1'b0;
        if (!accepted) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < IMG_WIDTH * IMG_HEIGHT; i++)
            send_beat(16'(base + i), (i == 0), ((i % IMG_WIDTH) == IMG_WIDTH - 1));
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp_sum,
                               input logic [15:0] exp_cnt, input logic [3:0] exp_err);
        #1;
        check({tag, "_done"},  32'(w_frame_done), 32'd1);
        check({tag, "_sum"},   w_checksum, exp_sum);
        check({tag, "_count"}, 32'(w_frame_count), 32'(exp_cnt));
        check({tag, "_lines"}, 32'(w_line_count), 32'd4);
        check({tag, "_err"},   32'(w_err), 32'(exp_err));
    endtask

    task automatic pulse_clear;
        r_clear_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_clear_err = 1'b0;
    endtask

    logic t_a, t_b;
    int   d;

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        n_done_pulses  = 0;
        rst_n          = 1'b0;
        r_enable       = 1'b0;
        r_bp           = 8'hFF;
        r_clear_err    = 1'b0;
        axis_if.tvalid = 1'b0;
        axis_if.tuser  = 1'b0;
        axis_if.tlast  = 1'b0;
        axis_if.tdata  = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_done",  32'(w_frame_done), 32'd0);
        check("rst_count", 32'(w_frame_count), 32'd0);
        check("rst_lines", 32'(w_line_count), 32'd0);
        check("rst_sum",   w_checksum, 32'd0);
        check("rst_err",   32'(w_err), 32'd0);
        check("rst_ready", 32'(axis_if.tready), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        r_enable = 1'b1;
        @(negedge clk);

        // 1: nominal frame, data 1..32
        send_frame(1);
        check_frame("t1", 32'd528, 16'd1, 4'b0000);
        @(negedge clk);
        #1 check("t1_pulse_len", 32'(w_frame_done), 32'd0);
        @(negedge clk);

        // 2: alternating ready
        r_bp = 8'b0101_0101;
        #1 t_a = axis_if.tready;
        @(negedge clk);
        #1 t_b = axis_if.tready;
        check("t2_toggle", 32'(t_a ^ t_b), 32'd1);
        @(negedge clk);
        send_frame(1);
        check_frame("t2", 32'd528, 16'd2, 4'b0000);
        r_bp = 8'hFF;
        @(negedge clk);

        // 3: line 1 ends after 6 pixels, 30 beats with data 1..30
        d = 1;
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < ((ln == 1) ? 6 : 8); px++) begin
                send_beat(16'(d), (d == 1), (ln == 1) ? (px == 5) : (px == 7));
                d++;
            end
        end
        check_frame("t3", 32'd465, 16'd3, 4'b0010);
        pulse_clear();
        #1 check("t3_clear", 32'(w_err), 32'd0);
        @(negedge clk);

        // 4: line 0 missing tlast, SOF on beat 12, then 31 beats of 2
        for (int i = 0; i < 11; i++) send_beat(16'd5, (i == 0), 1'b0);
        send_beat(16'd2, 1'b1, 1'b0);
        for (int i = 1; i < 32; i++) send_beat(16'd2, 1'b0, ((i % 8) == 7));
        check_frame("t4", 32'd64, 16'd4, 4'b0101);
        check("t4_pulses", 32'(n_done_pulses), 32'd4);
        pulse_clear();

        // 5: abort after two complete lines
        for (int i = 0; i < 16; i++) send_beat(16'd7, (i == 0), ((i % 8) == 7));
        r_enable = 1'b0;
        @(negedge clk);
        #1;
        check("t5_err",   32'(w_err), 32'b1000);
        check("t5_lines", 32'(w_line_count), 32'd2);
        check("t5_ready", 32'(axis_if.tready), 32'd0);
        check("t5_sum",   w_checksum, 32'd64);
        check("t5_count", 32'(w_frame_count), 32'd4);
        @(negedge clk);
        check("t5_pulses", 32'(n_done_pulses), 32'd4);
        pulse_clear();
        #1 check("t5_clear", 32'(w_err), 32'd0);

        // 6: reset mid-frame, then a clean frame
        r_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) send_beat(16'(i + 1), (i == 0), ((i % 8) == 7));
        rst_n = 1'b0;
        #1;
        check("t6_done",  32'(w_frame_done), 32'd0);
        check("t6_count", 32'(w_frame_count), 32'd0);
        check("t6_lines", 32'(w_line_count), 32'd0);
        check("t6_sum",   w_checksum, 32'd0);
        check("t6_err",   32'(w_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(1);
        check_frame("t6b", 32'd528, 16'd1, 4'b0000);
        @(negedge clk);
        #1 check("t6_pulses", 32'(n_done_pulses), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
